memory_arbiter: RTL
===================

MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 The block SHALL have one parameter, TIMEOUT, default 16, meaning the maximum number of cycles a granted access may wait for ACCESS.
REQ-002 The block SHALL have the following ports, clock and reset first:
- CLK  in  1  single clock, rising-edge
- RST  in  1  asynchronous, active-high reset
- halt  in  1  CPU halted; blocks new instruction fetches
- iREN  in  1  instruction read request
- iaddr  in  32  instruction address (word_t)
- iwait  out  1  instruction request not yet served
- iload  out  32  instruction read data
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  32  data address
- dstore  in  32  data write value
- dwait  out  1  data request not yet served
- dload  out  32  data read data
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  ramstate_t: FREE=0, BUSY=1, ACCESS=2, ERROR=3
- err  out  1  sticky error flag

Function
REQ-003 The FSM SHALL have states IDLE, IGNT, DGNT and FAULT.
REQ-004 In IDLE, the next state SHALL be:
- DGNT if (dREN or dWEN) is high;
- else IGNT if iREN is high and halt is low;
- else IDLE.
Data requests therefore always take priority.
REQ-005 While in DGNT, the RAM port SHALL be driven as follows:
- ramaddr=daddr, ramstore=dstore, ramREN=dREN, ramWEN=dWEN;
- if dREN and dWEN are both high, ramWEN=1 and ramREN=0 (write wins).
REQ-006 While in IGNT, the RAM port SHALL be driven ramaddr=iaddr, ramREN=1, ramWEN=0, ramstore=0.
REQ-007 In IDLE and FAULT, ramREN, ramWEN, ramaddr and ramstore SHALL all be 0.
REQ-008 In a granted state, when ramstate==ACCESS the matching wait signal SHALL be low for that same cycle and the FSM SHALL return to IDLE on the next edge.
REQ-009 For a completed read, dload (or iload) SHALL equal ramload combinationally in the completion cycle; both SHALL be 0 otherwise.
REQ-010 iwait and dwait SHALL be high in every cycle except the completion cycle of their own grant.
REQ-011 The minimum request-to-completion latency SHALL be 2 cycles: grant on edge 1, completion in the following cycle if ramstate==ACCESS.
REQ-012 If the granted request deasserts before ACCESS, the arbiter SHALL drop RAM enables combinationally and return to IDLE on the next edge, with no completion pulse.
REQ-013 A wait counter SHALL:
- clear on entry to IGNT or DGNT;
- increment each granted cycle that ramstate is not ACCESS;
- saturate at TIMEOUT.
REQ-014 When the counter reaches TIMEOUT, or ramstate==ERROR in a granted state, the FSM SHALL go to FAULT and set err.
REQ-015 FAULT SHALL hold iwait=dwait=1 and be left only by reset.
REQ-016 halt SHALL NOT abort an in-progress IGNT; it only blocks new instruction grants from IDLE.
REQ-017 Simultaneous iREN and dREN in IDLE SHALL grant data first; the instruction request is granted after the data access completes (IDLE → DGNT → IDLE → IGNT).

Reset
REQ-018 RST high SHALL asynchronously force:
- state=IDLE, counter=0, err=0;
- all RAM outputs 0;
- iwait=dwait=1.
REQ-019 A reset asserted mid-access SHALL abandon the access with no completion pulse.

Structure
REQ-020 ramstate_t, the FSM state enum, and word_t SHALL reside in cpu_types_pkg; TIMEOUT stays a module parameter.
REQ-021 The saturating wait counter SHALL be a sub-module named wait_counter (inputs clear, enable; output done).

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- iREN=1, iaddr=0x40, ramstate=ACCESS in the first granted cycle → iwait low exactly 1 cycle, iload=ramload=0x8C010004.
- dWEN=1, daddr=0x100, dstore=0xDEADBEEF with iREN=1 → RAM write to 0x100 granted first; the instruction grant follows after one IDLE cycle.
- ramstate=BUSY for 3 cycles then ACCESS on a data read → dwait high 4 cycles, then low 1 cycle with dload=ramload.
- ramstate held BUSY with TIMEOUT=16 → err=1 after 16 granted cycles, FAULT state, waits stuck high until RST.
- halt=1, iREN=1 from IDLE → no grant and ramREN=0; RST pulse mid-DGNT → all outputs reset immediately.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-side types: word, RAM handshake state and arbiter FSM state.
// Pure type package, no logic; used by the arbiter and its bench-facing ports.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IGNT  = 2'd1,
        DGNT  = 2'd2,
        FAULT = 2'd3
    } arb_state_t;

endpackage

// File: rtl/wait_counter.sv
// Saturating count of granted cycles spent waiting on RAM; done flags the TIMEOUT-th wait.
// Latency: done is combinational on the cycle the limit is hit; no backpressure.
module wait_counter #(
    parameter int TIMEOUT = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic clear,
    input  logic enable,
    output logic done
);

    localparam int W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

    logic [W-1:0] count;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != LIMIT) begin
            count <= count + 1'b1;
        end
    end

    // Raised during the wait cycle that would bring the count to LIMIT, so the
    // arbiter leaves on the edge ending the TIMEOUT-th waiting cycle.
    assign done = (count == LIMIT) || (enable && count == LIMIT - 1'b1);

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates instruction and data ports onto one RAM port, data first, with timeout/error fault.
// Latency: grant on the edge after request, completion combinational on ACCESS; waits held high until served.
module memory_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        halt,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        err
);

    import cpu_types_pkg::*;

    arb_state_t state, next_state;
    ramstate_t  rs;
    logic       dreq, granted, gnt_req, complete, timeout;

    assign rs       = ramstate_t'(ramstate);
    assign dreq     = dREN | dWEN;
    assign granted  = (state == IGNT) || (state == DGNT);
    assign gnt_req  = (state == IGNT) ? iREN : ((state == DGNT) ? dreq : 1'b0);
    assign complete = gnt_req && (rs == ACCESS);

    wait_counter #(.TIMEOUT(TIMEOUT)) u_wait_counter (
        .CLK    (CLK),
        .RST    (RST),
        .clear  (!granted),
        .enable (gnt_req && (rs != ACCESS)),
        .done   (timeout)
    );

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (dreq) begin
                    next_state = DGNT;
                end else if (iREN && !halt) begin
                    next_state = IGNT;
                end
            end
            IGNT, DGNT: begin
                // A withdrawn request abandons the grant before any fault check.
                if (!gnt_req || complete) begin
                    next_state = IDLE;
                end else if (rs == ERROR || timeout) begin
                    next_state = FAULT;
                end
            end
            default: next_state = FAULT;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            err   <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state == FAULT) begin
                err <= 1'b1;
            end
        end
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state)
            DGNT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
            end
            IGNT: begin
                ramaddr = iaddr;
                ramREN  = iREN;
            end
            default: ;
        endcase
    end

    assign iwait = !((state == IGNT) && complete);
    assign dwait = !((state == DGNT) && complete);
    assign iload = ((state == IGNT) && complete) ? ramload : '0;
    assign dload = ((state == DGNT) && complete && dREN && !dWEN) ? ramload : '0;

endmodule
